// File: rtl/adc_128s.sv
// adc_128s: SPI-mode-0 slave emulating a 128S-style ADC; returns one of three 12-bit
// settings per frame. Optional chan_err flag enabled by defining ADC_CHAN_ERR_EN.
module adc_128s #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic [11:0] batt_set,
  input  logic [11:0] lft_cell_set,
  input  logic [11:0] rght_cell_set,
  output logic        MISO
`ifdef ADC_CHAN_ERR_EN
  ,
  output logic        chan_err
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic                   ss_q, sclk_q, mosi_q;
  logic [SYNC_STAGES:0]   flush;
  logic                   armed;

  logic [15:0] rx, tx, rx_next;
  logic [4:0]  bit_cnt;
  logic [2:0]  channel;
  logic [11:0] result;

  logic load_tx, rise_en, fall_en, latch_ch;
  logic ss_fall, sclk_rise, sclk_fall;

  assign ss_q   = ss_sync[SYNC_STAGES-1];
  assign sclk_q = sclk_sync[SYNC_STAGES-1];
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_d      <= ss_q;
      sclk_d    <= sclk_q;
    end
  end

  // The synchronizer resets to "SS_n high", so a select held low across reset would
  // look like a fresh fall; only arm once a genuinely sampled high has reached ss_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush <= '0;
      armed <= 1'b0;
    end else begin
      flush <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && ss_q)
        armed <= 1'b1;
    end
  end

  assign ss_fall   = armed && ss_d && !ss_q;
  assign sclk_rise = !sclk_d && sclk_q;
  assign sclk_fall = sclk_d && !sclk_q;
  assign rx_next   = {rx[14:0], mosi_q};

  always_comb begin
    result = '0;
    case (channel)
      3'd0:    result = lft_cell_set;
      3'd4:    result = rght_cell_set;
      3'd5:    result = batt_set;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    rise_en    = 1'b0;
    fall_en    = 1'b0;
    latch_ch   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_q) begin
          state_next = IDLE;
        end else if (sclk_rise) begin
          rise_en = 1'b1;
          if (bit_cnt == 5'd15) begin
            latch_ch   = 1'b1;
            state_next = DONE;
          end
        end else if (sclk_fall && bit_cnt != 5'd0) begin
          fall_en = 1'b1;
        end
      end
      DONE: begin
        if (ss_q)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx      <= '0;
      tx      <= '0;
      bit_cnt <= '0;
      channel <= '0;
    end else begin
      if (load_tx) begin
        tx      <= {4'h0, result};
        rx      <= '0;
        bit_cnt <= '0;
      end
      if (rise_en) begin
        rx      <= rx_next;
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (fall_en)
        tx <= {tx[14:0], 1'b0};
      if (latch_ch)
        channel <= rx_next[13:11];
    end
  end

`ifdef ADC_CHAN_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)
      chan_err <= 1'b0;
    else if (latch_ch)
      chan_err <= !(rx_next[13:11] == 3'd0 || rx_next[13:11] == 3'd4 ||
                    rx_next[13:11] == 3'd5);
  end
`endif

  assign MISO = (state == SHIFT) && tx[15];

endmodule

// File: tb/tb_adc_128s.sv
// Scoreboard bench for adc_128s: stimulus queues expected MISO words, a monitor
// collects 16-bit words as an SPI master would and compares them.
module tb_adc_128s;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic [11:0] batt_set, lft_cell_set, rght_cell_set;
  logic        MISO;
`ifdef ADC_CHAN_ERR_EN
  logic        chan_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  adc_128s #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .batt_set     (batt_set),
    .lft_cell_set (lft_cell_set),
    .rght_cell_set(rght_cell_set),
    .MISO         (MISO)
`ifdef ADC_CHAN_ERR_EN
    ,
    .chan_err     (chan_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: acts as the SPI master's receiver, sampling MISO on each SCLK rise.
  initial begin
    logic [15:0] word;
    int          n;
    logic [15:0] exp;
    forever begin
      @(negedge SS_n);
      n    = 0;
      word = '0;
      while (!SS_n && !rst) begin
        @(posedge SCLK or posedge SS_n or posedge rst);
        if (!SS_n && !rst && SCLK && n < 16) begin
          word = {word[14:0], MISO};
          n++;
          if (n == 16) begin
            if (exp_q.size() == 0) begin
              check("unexpected_word", word, 16'hxxxx);
            end else begin
              exp = exp_q.pop_front();
              check("miso_word", word, exp);
            end
          end
        end
      end
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_bits(input logic [15:0] w, input int nrise,
                         input int chg_bit, input logic [11:0] chg_val);
    for (int i = 0; i < nrise; i++) begin
      if (i == chg_bit) batt_set = chg_val;
      MOSI = w[15-i];
      clocks(4);
      SCLK = 1'b1;
      clocks(8);
      SCLK = 1'b0;
      clocks(4);
    end
  endtask

  task automatic frame(input logic [15:0] w, input logic [15:0] exp,
                       input int chg_bit, input logic [11:0] chg_val);
    exp_q.push_back(exp);
    SS_n = 1'b0;
    clocks(8);
    do_bits(w, 16, chg_bit, chg_val);
    check("miso_done", {15'd0, MISO}, 16'd0);
    SS_n = 1'b1;
    MOSI = 1'b0;
    clocks(8);
  endtask

  task automatic aborted(input logic [15:0] w, input int nrise);
    SS_n = 1'b0;
    clocks(8);
    do_bits(w, nrise, -1, 12'h000);
    SS_n = 1'b1;
    MOSI = 1'b0;
    clocks(8);
  endtask

`ifdef ADC_CHAN_ERR_EN
  task automatic check_err(input logic e);
    check("chan_err", {15'd0, chan_err}, {15'd0, e});
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    batt_set = '0; lft_cell_set = '0; rght_cell_set = '0;
    clocks(5);
    rst = 1'b0;
    clocks(1);
    check("miso_reset", {15'd0, MISO}, 16'd0);
`ifdef ADC_CHAN_ERR_EN
    check_err(1'b0);
`endif
    clocks(8);

    frame(16'h0000, 16'h0000, -1, 12'h000);
    lft_cell_set = 12'h130;
    frame(16'h0000, 16'h0130, -1, 12'h000);
    batt_set = 12'hD80;
    frame(16'h2800, 16'h0130, -1, 12'h000);
    frame(16'h2000, 16'h0D80, -1, 12'h000);
    rght_cell_set = 12'h200;
    frame(16'h0000, 16'h0200, -1, 12'h000);

    // channel 5 frame aborted after 8 rises: channel stays 0
    aborted(16'h2800, 8);
    frame(16'h1800, 16'h0130, -1, 12'h000);
`ifdef ADC_CHAN_ERR_EN
    check_err(1'b1);
`endif
    frame(16'h2800, 16'h0000, -1, 12'h000);
`ifdef ADC_CHAN_ERR_EN
    check_err(1'b0);
`endif
    batt_set = 12'h100;
    frame(16'h2800, 16'h0100, 4, 12'h200);
    frame(16'h0000, 16'h0200, -1, 12'h000);
`ifdef ADC_CHAN_ERR_EN
    check_err(1'b0);
`endif

    lft_cell_set = 12'hA55;
    frame(16'h3800, 16'h0A55, -1, 12'h000);
`ifdef ADC_CHAN_ERR_EN
    check_err(1'b1);
`endif
    frame(16'h0800, 16'h0000, -1, 12'h000);
`ifdef ADC_CHAN_ERR_EN
    check_err(1'b1);
`endif
    frame(16'h0000, 16'h0000, -1, 12'h000);
`ifdef ADC_CHAN_ERR_EN
    check_err(1'b0);
`endif
    frame(16'h2800, 16'h0A55, -1, 12'h000);

    // reset mid-frame, release with SS_n still low: DUT must stay idle
    SS_n = 1'b0;
    clocks(8);
    do_bits(16'h2000, 4, -1, 12'h000);
    rst = 1'b1;
    clocks(3);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      MOSI = (i == 2) ? 1'b1 : 1'b0;
      clocks(4);
      check("miso_post_rst", {15'd0, MISO}, 16'd0);
      SCLK = 1'b1;
      clocks(8);
      SCLK = 1'b0;
      clocks(4);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    clocks(8);
    frame(16'h0000, 16'h0A55, -1, 12'h000);

    clocks(20);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
